// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Purpose  : Shared types and constants for the APB3 requester bridge.
//            Holds the FSM state encoding, the latched command record and
//            the word-alignment constant.
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

   // Native bus widths of the bridge; the command record is sized from these,
   // so apb_master must be built with matching ADDR_WIDTH/DATA_WIDTH.
   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   // Low address bits of a word-aligned access.
   localparam logic [1:0] APB_ALIGN_OK = 2'b00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_cmd_t;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : apb_timeout_cnt
// Purpose  : Counts ACCESS wait cycles and flags the last permitted one.
//            o_expired is high during the wait cycle that brings the count
//            to TIMEOUT_CYCLES, so the requester can abort on that edge.
//            Only instantiated when APB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module apb_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int              CW     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0]   C_ONE  = CW'(1);

   logic [CW-1:0] r_count;

   // Wait-cycle counter: cleared before each ACCESS, advances on every stalled cycle.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + C_ONE;
      end
   end

   assign o_expired = i_enable && (r_count == C_LAST);

endmodule : apb_timeout_cnt
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Purpose  : APB3 requester bridge. Takes single read/write commands on a
//            valid/ready port, runs the SETUP/ACCESS phases, and returns
//            read data and error status on a held response port.
//            Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after
//            TIMEOUT_CYCLES stalled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_W,
   parameter int DATA_WIDTH     = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk,
   input  logic                  preset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   apb_state_e            r_state;
   apb_cmd_t              r_cmd;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;
   logic                  w_expired;

`ifdef APB_TIMEOUT_EN
   apb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (pclk),
      .rst       (preset),
      .i_clear   (r_state == SETUP),
      .i_enable  ((r_state == ACCESS) && !pready),
      .o_expired (w_expired)
   );
`else
   // ACCESS waits for pready indefinitely; the limit parameter has no role.
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
   assign w_expired        = 1'b0;
`endif

   // Transfer sequencer: all bus and response outputs are registered here.
   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state     <= IDLE;
         r_cmd       <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  r_cmd <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
                  if (cmd_addr[1:0] != APB_ALIGN_OK) begin
                     // Misaligned: answer with an error without touching the bus.
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                     r_state     <= RESP;
                  end else begin
                     r_psel  <= 1'b1;
                     r_state <= SETUP;
                  end
               end
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ACCESS;
            end
            ACCESS: begin
               if (pready) begin
                  r_rsp_rdata <= r_cmd.write ? '0 : prdata;
                  r_rsp_err   <= pslverr;
                  r_rsp_valid <= 1'b1;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_state     <= RESP;
               end else if (w_expired) begin
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (r_state == IDLE);
   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pwrite    = r_cmd.write;
   assign paddr     = r_cmd.addr;
   assign pwdata    = r_cmd.wdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule : apb_master
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Purpose  : Self-checking bench for apb_master with a wait-state memory
//            completer, a transaction-level reference model and directed
//            transfers with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master;

   localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic        pclk      = 1'b0;
   logic        preset    = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr  = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_ready = 1'b0;
   logic        cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
   logic [31:0] rsp_rdata, paddr, pwdata, prdata;
   logic        pready, pslverr;

   int tests = 0;
   int fails = 0;

   always #5 pclk = ~pclk;

   apb_master #(
      .ADDR_WIDTH     (32),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .pclk      (pclk),
      .preset    (preset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory completer with programmable wait states --------
   int          slv_waits = 0;   // negative = never ready
   bit          slv_err   = 1'b0;
   int          wcnt      = 0;
   bit          mem_init  = 1'b0;
   logic [31:0] mem [0:63];

   assign pready  = psel && penable && (slv_waits >= 0) && (wcnt >= slv_waits);
   assign pslverr = slv_err;
   assign prdata  = mem[paddr[7:2]];

   always @(posedge pclk) begin
      if (!mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
         mem_init <= 1'b1;
      end else if (psel && penable && pready && pwrite) begin
         mem[paddr[7:2]] <= pwdata;
      end
      if (psel && penable && !pready) wcnt <= wcnt + 1;
      else                            wcnt <= 0;
   end

   // ---------------- transaction-level reference model ---------------------
   typedef struct {
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   exp_t        q[$];
   bit          busy     = 1'b0;
   bit          model_on = 1'b0;
   bit          ref_init = 1'b0;
   logic [31:0] ref_mem [0:63];

   always @(negedge pclk) begin
      exp_t e;
      if (!ref_init) begin
         for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 | i;
         ref_init = 1'b1;
      end
      if (model_on) begin
         check("model_cmd_ready", cmd_ready, !busy);
         check("model_psel_when_idle", psel && !busy, 0);
         if (rsp_valid) begin
            if (q.size() == 0) begin
               check("model_rsp_spurious", rsp_valid, 0);
            end else begin
               check("model_rsp_rdata", rsp_rdata, q[0].rdata);
               check("model_rsp_err", rsp_err, q[0].err);
            end
         end
      end
      if (preset) begin
         busy = 1'b0;
         q.delete();
      end else begin
         if (rsp_valid && rsp_ready && q.size() > 0) begin
            void'(q.pop_front());
            busy = 1'b0;
         end
         if (cmd_valid && cmd_ready) begin
            if (cmd_addr[1:0] != 2'b00) begin
               e = '{32'h0, 1'b1};
            end else if (slv_waits < 0 && TO_ON) begin
               e = '{32'h0, 1'b1};
            end else if (cmd_write) begin
               e = '{32'h0, slv_err};
               if (!slv_err) ref_mem[cmd_addr[7:2]] = cmd_wdata;
            end else begin
               e = '{ref_mem[cmd_addr[7:2]], slv_err};
            end
            q.push_back(e);
            busy = 1'b1;
         end
      end
   end

   // ---------------- directed driver ---------------------------------------
   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   // access = expected ACCESS-phase length in cycles
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input int waits, input bit err, input int access, input int hold,
                       input logic [31:0] exp_rdata, input bit exp_err);
      bit mis;
      int lat, nsel, nen;
      mis       = (addr[1:0] != 2'b00);
      slv_waits = waits;
      slv_err   = err;
      check("idle_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      tick;
      cmd_valid = 1'b0;
      lat = 0; nsel = 0; nen = 0;
      for (int k = 1; k <= 300; k++) begin
         if (k == 1 && !mis) begin
            check("setup_psel", psel, 1);
            check("setup_penable", penable, 0);
            check("setup_paddr", paddr, addr);
            check("setup_pwrite", pwrite, wr);
            check("setup_pwdata", pwdata, data);
         end
         if (psel)    nsel++;
         if (penable) nen++;
         if (rsp_valid) begin
            lat = k;
            break;
         end
         tick;
      end
      check("rsp_latency", lat, mis ? 1 : 2 + access);
      check("psel_cycles", nsel, mis ? 0 : 1 + access);
      check("penable_cycles", nen, mis ? 0 : access);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_err", rsp_err, exp_err);
      for (int h = 0; h < hold; h++) begin
         tick;
         check("hold_rsp_valid", rsp_valid, 1);
         check("hold_rsp_rdata", rsp_rdata, exp_rdata);
         check("hold_rsp_err", rsp_err, exp_err);
         check("hold_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check("rsp_dropped", rsp_valid, 0);
      check("back_to_idle", cmd_ready, 1);
      slv_err   = 1'b0;
      slv_waits = 0;
   endtask

   initial begin
      preset = 1'b1;
      repeat (3) tick;
      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_pwrite", pwrite, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      preset   = 1'b0;
      model_on = 1'b1;
      tick;

      // write with one wait, then read it back with two waits
      xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 1'b0, 2, 0, 32'h0, 1'b0);
      xfer(1'b0, 32'h0000_0010, 32'h0, 2, 1'b0, 3, 0, 32'hDEAD_BEEF, 1'b0);
      // zero-wait read
      xfer(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 1, 0, 32'hDEAD_BEEF, 1'b0);
      // misaligned read
      xfer(1'b0, 32'h0000_0006, 32'h0, 0, 1'b0, 0, 0, 32'h0, 1'b1);
      // slave error on a write, response held off for 5 cycles
      xfer(1'b1, 32'h0000_0020, 32'h1234_5678, 0, 1'b1, 1, 5, 32'h0, 1'b0 | 1'b1);
      // untouched location, short backpressure
      xfer(1'b0, 32'h0000_0024, 32'h0, 1, 1'b0, 2, 2, 32'hA500_0009, 1'b0);

      // completer never ready, then reset in the middle of ACCESS
      slv_waits = -1;
      check("stuck_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0000_0030;
      tick;
      cmd_valid = 1'b0;
      tick;
      check("stuck_penable", penable, 1);
`ifndef APB_TIMEOUT_EN
      repeat (100) tick;
      check("stuck_psel_100", psel, 1);
      check("stuck_penable_100", penable, 1);
`endif
      preset = 1'b1;
      tick;
      check("midrst_psel", psel, 0);
      check("midrst_penable", penable, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_cmd_ready", cmd_ready, 1);
      preset    = 1'b0;
      slv_waits = 0;
      tick;

`ifdef APB_TIMEOUT_EN
      // stuck completer: ACCESS is abandoned after TO cycles
      xfer(1'b0, 32'h0000_0030, 32'h0, -1, 1'b0, TO, 0, 32'h0, 1'b1);
`endif

      // recovery after reset: earlier write must still be readable
      xfer(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 1, 0, 32'hDEAD_BEEF, 1'b0);

      repeat (2) tick;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_apb_master
`default_nettype wire

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB3 requester bridge, directly upstream of the APB completer (memory slave) on the same pclk domain.
- Accepts single read/write commands on a valid/ready command port and sequences the APB SETUP/ACCESS phases.
- Waits on pready and returns read data plus error status on a held response port.
- One outstanding transfer at a time; no pipelining across APB transfers.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr/paddr.
- DATA_WIDTH, 32, width of wdata/rdata buses.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; used only with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  clock, all logic on rising edge.
- preset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available, held until accepted.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  pslverr, misalignment or timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB completer ready.
- pslverr  in  1  APB completer error.

Behaviour:
- Clock and reset: one clock, pclk; reset preset is synchronous and active-high.
- All outputs are registered, except cmd_ready, which decodes combinationally from state.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
- Reset mid-transfer: all of the above take effect at the next edge. The in-flight command is dropped and no response is produced.
- State IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_write/addr/wdata.
  - If cmd_addr[1:0]!=0: go RESP with rsp_err=1, rsp_rdata=0; no APB activity.
  - Otherwise: go SETUP.
- State SETUP: psel=1, penable=0, and paddr/pwrite/pwdata driven from the latch. Always lasts exactly one cycle, then goes ACCESS.
- State ACCESS: psel=1, penable=1, and paddr/pwrite/pwdata stable.
  - Stays in ACCESS while pready=0.
  - On pready=1, capture rsp_rdata = pwrite ? 0 : prdata and rsp_err = pslverr, then go RESP.
  - psel/penable deassert on the same edge that enters RESP.
- State RESP: rsp_valid=1, with rdata/err held stable.
  - On rsp_ready=1: rsp_valid drops at the next edge and the state returns to IDLE.
  - If rsp_ready is already high on entry, RESP lasts one cycle.
- cmd_ready=0 in SETUP, ACCESS and RESP. A command cannot be accepted on the cycle a response is consumed.
- Latency: command accepted at edge N gives SETUP cycle N+1 and ACCESS from N+2. With a zero-wait completer, rsp_valid is high at N+3. Each pready wait cycle adds one cycle.
- Minimum transfer period: 4 cycles (IDLE, SETUP, ACCESS, RESP).
- pwdata is driven for reads as well (latched value); completer ignores it.
- pslverr is sampled only in ACCESS with pready=1; pslverr is ignored at all other times.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES, the block leaves ACCESS with rsp_err=1 and rsp_rdata=0, and psel/penable deassert.
  - If pready=1 arrives on that same cycle, the normal completion wins.
- Without the macro: ACCESS waits indefinitely for pready; no counter logic.

Decomposition:
- Package apb_pkg holds:
  - apb_state_e enum: IDLE, SETUP, ACCESS, RESP.
  - apb_cmd_t struct: write, addr, wdata.
  - Localparam constants for the alignment mask (2'b00).
- Sub-module apb_timeout_cnt (clear, enable, expired), instantiated only under APB_TIMEOUT_EN.
- Everything else stays in apb_master.

Test Plan:
- Reset mid-ACCESS: assert preset while penable=1 -> next edge psel=0, penable=0, rsp_valid=0, cmd_ready=1.
- Write then read:
  - Write addr 0x0000_0010, data 0xDEAD_BEEF, to a memory slave model with 1 write wait.
  - Then read 0x10 with 2 read waits.
  - Required: rsp_rdata=0xDEAD_BEEF, rsp_err=0, ACCESS lasting 2 and 3 cycles respectively.
- Zero-wait timing: read with pready tied 1 -> rsp_valid high exactly 3 cycles after acceptance; psel high 2 cycles, penable high 1 cycle.
- Misaligned: read addr 0x0000_0006 -> psel never asserts; rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
- Backpressure and pslverr:
  - pslverr=1 with pready=1 on a write -> rsp_err=1.
  - Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_err stable, cmd_ready=0 throughout.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4): pready stuck 0 -> ACCESS ends after 4 cycles with rsp_err=1, rsp_rdata=0. Without the macro, psel is still high after 100 cycles.
